// File: rtl/fccc_clk_manager.sv
// Fabric-side companion to the CCC wrapper: debounces PLL LOCK, sequences the
// fabric reset release, counts lock losses and generates per-channel clock enables.
module fccc_clk_manager #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 16,
    parameter int LOCK_FILT = 1024,
    parameter int RST_DLY   = 16,
    parameter int CNT_W     = 8,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_lock,
    input  logic              i_wr_en,
    input  logic [CH_W-1:0]   i_wr_ch,
    input  logic [DIV_W-1:0]  i_wr_div,
    output logic              o_wr_ack,
    output logic [NUM_CH-1:0] o_ce,
    output logic              o_locked,
    output logic              o_fabric_reset_n,
    output logic [CNT_W-1:0]  o_loss_cnt,
    output logic [1:0]        o_state
);

    localparam logic [1:0] S_UNLOCKED = 2'd0;
    localparam logic [1:0] S_FILTER   = 2'd1;
    localparam logic [1:0] S_DELAY    = 2'd2;
    localparam logic [1:0] S_RUN      = 2'd3;

    localparam int FC_MAX = (LOCK_FILT > RST_DLY) ? LOCK_FILT : RST_DLY;
    localparam int FC_W   = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;
    // The UNLOCKED cycle that first sees lock_s high counts as the first filter cycle.
    localparam logic [FC_W-1:0] FILT_END = FC_W'(LOCK_FILT - 2);
    localparam logic [FC_W-1:0] DLY_END  = FC_W'(RST_DLY - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [FC_W-1:0]   r_cnt;
    logic [FC_W-1:0]   w_cnt_nxt;
    logic              w_loss;
    logic [CNT_W-1:0]  r_loss_cnt;
    logic              r_wr_ack;
    logic              w_wr_valid;
    logic [NUM_CH-1:0] w_wr_hit;
    logic [NUM_CH-1:0] r_ce;
    logic [NUM_CH-1:0] w_ce_nxt;
    logic              w_lock_s;
    logic              w_run;
    logic              w_run_nxt;

    assign w_lock_s  = r_sync2;
    assign w_run     = (r_state == S_RUN);
    assign w_run_nxt = (w_state_nxt == S_RUN);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_loss      = 1'b0;
        case (r_state)
            S_UNLOCKED: begin
                if (w_lock_s) begin
                    w_state_nxt = S_FILTER;
                end
            end
            S_FILTER: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_UNLOCKED;
                end else if (r_cnt == FILT_END) begin
                    w_state_nxt = S_DELAY;
                end else begin
                    w_cnt_nxt = r_cnt + FC_W'(1);
                end
            end
            S_DELAY: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_UNLOCKED;
                    w_loss      = 1'b1;
                end else if (r_cnt == DLY_END) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + FC_W'(1);
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_UNLOCKED;
                    w_loss      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_UNLOCKED;
            end
        endcase
    end

    // Write port: a write is accepted whenever i_wr_en is high with an in-range
    // i_wr_ch (no back-pressure); o_wr_ack pulses for one cycle in the cycle after.
    generate
        if (NUM_CH == (1 << CH_W)) begin : g_full_range
            assign w_wr_valid = 1'b1;
        end else begin : g_part_range
            localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);
            assign w_wr_valid = ({1'b0, i_wr_ch} < NUM_CH_L);
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [DIV_W-1:0] r_div;
            logic [DIV_W-1:0] r_chcnt;
            logic [DIV_W-1:0] w_div_nxt;
            logic [DIV_W-1:0] w_chcnt_nxt;

            assign w_wr_hit[i] = i_wr_en && w_wr_valid && (i_wr_ch == CH_W'(i));
            assign w_div_nxt   = w_wr_hit[i] ? i_wr_div : r_div;

            // Counters sit at 0 outside RUN so every channel starts phase-aligned.
            always_comb begin
                w_chcnt_nxt = '0;
                if (!w_wr_hit[i] && w_run && w_run_nxt && (r_div != '0)
                        && (r_chcnt != (r_div - DIV_W'(1)))) begin
                    w_chcnt_nxt = r_chcnt + DIV_W'(1);
                end
            end

            // CE is registered, so it is decoded from the next-cycle counter and divisor.
            assign w_ce_nxt[i] = w_run_nxt && (w_div_nxt != '0)
                                 && (w_chcnt_nxt == (w_div_nxt - DIV_W'(1)));

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_div   <= DIV_W'(1);
                    r_chcnt <= '0;
                end else begin
                    r_div   <= w_div_nxt;
                    r_chcnt <= w_chcnt_nxt;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_state    <= S_UNLOCKED;
            r_cnt      <= '0;
            r_loss_cnt <= '0;
            r_wr_ack   <= 1'b0;
            r_ce       <= '0;
        end else begin
            r_sync1  <= i_lock;
            r_sync2  <= r_sync1;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wr_ack <= i_wr_en && w_wr_valid;
            r_ce     <= w_ce_nxt;
            if (w_loss && (r_loss_cnt != {CNT_W{1'b1}})) begin
                r_loss_cnt <= r_loss_cnt + CNT_W'(1);
            end
        end
    end

    assign o_wr_ack         = r_wr_ack;
    assign o_ce             = r_ce;
    assign o_locked         = (r_state == S_DELAY) || (r_state == S_RUN);
    assign o_fabric_reset_n = w_run;
    assign o_loss_cnt       = r_loss_cnt;
    assign o_state          = r_state;

endmodule

// File: doc/fccc_clk_manager.md
Name: fccc_clk_manager

Overview:
- Parametrised fabric-side companion to the CCC clock wrapper. It qualifies the raw PLL LOCK with a debounce filter and sequences a fabric reset release.
- It generates NUM_CH phase-aligned clock-enable strobes from the single global clock, each with a runtime-programmable divisor.
- It counts lock-loss events.
- It sits directly after the CCC instance and feeds CE/reset to all fabric logic clocked from GL0.

Parameters:
- NUM_CH, 4, number of clock-enable channels (1..16)
- DIV_W, 16, divisor register width per channel
- LOCK_FILT, 1024, consecutive synchronised-LOCK-high cycles required before LOCKED asserts (>=2)
- RST_DLY, 16, cycles FABRIC_RESET_N is held low after LOCKED asserts (>=1)
- CNT_W, 8, width of saturating lock-loss counter

Ports:
- CLK  in  1  global fabric clock (GL0 of the CCC)
- RESET  in  1  synchronous, active-high reset
- LOCK  in  1  raw PLL lock, asynchronous to CLK
- WR_EN  in  1  divisor write strobe
- WR_CH  in  clog2(NUM_CH) (min 1)  channel index for write
- WR_DIV  in  DIV_W  new divisor value
- WR_ACK  out  1  one-cycle pulse confirming an accepted write
- CE  out  NUM_CH  per-channel clock-enable strobes, registered
- LOCKED  out  1  filtered lock status
- FABRIC_RESET_N  out  1  active-low reset for downstream fabric
- LOSS_CNT  out  CNT_W  saturating count of lock losses

Behaviour:
- Single clock CLK. Reset is synchronous and active-high on RESET. All state is updated on the rising edge of CLK.
- On RESET, including mid-operation:
  - state=UNLOCKED; CE=0; LOCKED=0; FABRIC_RESET_N=0; WR_ACK=0; LOSS_CNT=0.
  - All divisors=1; all channel counters=0; filter/delay counter=0; sync flops=0.
- LOCK is passed through a 2-flop synchroniser; lock_s is its output.
- FSM states:
  - UNLOCKED: counter=0. lock_s=1 -> FILTER.
  - FILTER: counter increments each cycle.
    - lock_s=0 -> UNLOCKED (counter cleared, no LOSS_CNT increment).
    - Counter reaches LOCK_FILT-1 with lock_s=1 -> DELAY; LOCKED=1 from the first DELAY cycle; counter cleared.
  - DELAY: FABRIC_RESET_N=0; counter increments. On reaching RST_DLY-1 -> RUN; FABRIC_RESET_N=1 from the first RUN cycle.
  - RUN: channel dividers active.
- Lock loss: lock_s=0 in DELAY or RUN -> UNLOCKED.
  - Next cycle: LOCKED=0, FABRIC_RESET_N=0, CE=0.
  - LOSS_CNT increments, saturating at all-ones.
- Divider channel i, divisor D:
  - Outside RUN: counter held at 0, CE[i]=0.
  - In RUN, with k = cycle index since RUN entry (k=0 is the first RUN cycle): CE[i]=1 iff D!=0 and (k mod D)==D-1.
  - D=1 gives CE[i] continuously high. D=0 disables the channel (CE[i]=0).
  - Counter wraps D-1 -> 0.
  - All channels start at 0 on RUN entry, so they are phase-aligned.
- Write handling:
  - WR_EN=1 with WR_CH<NUM_CH in cycle t loads the divisor and clears that channel's counter at the end of t.
  - From cycle t+1 the channel behaves as if k restarted at 0 with the new D.
  - WR_ACK=1 in cycle t+1.
  - A write to a channel already at counter D-1 in cycle t still produces that cycle's CE.
- WR_CH>=NUM_CH: write ignored, no WR_ACK.
- Writes are accepted in every state; divisors persist across lock loss but not across RESET.
- Simultaneous write and lock loss: both take effect; the channel restarts from 0 at the next RUN entry.
- All widths unsigned. The k/D comparison uses DIV_W bits with no truncation.

Test Plan:
Bench parameters: LOCK_FILT=8, RST_DLY=4, NUM_CH=4.
- Reset then LOCK=1 held -> LOCKED=1 exactly 2+8 cycles after LOCK rises; FABRIC_RESET_N=1 four cycles after that; CE[0] (D=1) high every cycle from the first RUN cycle.
- LOCK glitch high for 5 cycles, then low -> LOCKED stays 0, LOSS_CNT stays 0; a subsequent clean LOCK reaches RUN normally.
- In RUN, write D=3 to ch1 and D=0 to ch2 -> WR_ACK pulses one cycle after each write; CE[1] high on cycles 2,5,8 after the write takes effect; CE[2] constantly 0; WR_CH=5 produces no WR_ACK and no change.
- Lock loss in RUN -> next cycle LOCKED=0, FABRIC_RESET_N=0, CE=0, LOSS_CNT=1. Repeated losses with CNT_W=2 saturate LOSS_CNT at 3.
- Lock loss during DELAY -> LOSS_CNT increments; FABRIC_RESET_N never rises until the full filter+delay sequence is redone.
- RESET asserted mid-RUN with D=7 on ch3 -> all outputs return to reset values next cycle; after relock, ch3 runs with D=1.
